instr_fetch_unit: RTL and testbench

- Upstream neighbour of the control unit. Owns the program counter and fetches each 40-bit instruction from a byte-wide program memory, five bytes per instruction, most-significant byte first.
- Drives the control unit's instruction and pc inputs and loads the control unit's next_pc at the end of WRITEBACK.
- Exposes fetch_busy so the core can hold the control unit in FETCH until the instruction is complete.

---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_byte_assembler.sv | 35 +++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared instruction-set types and fetch constants
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } STATE_T;

    localparam int INSTR_BYTES = 5;

    typedef enum logic [1:0] {
        F_START = 2'd0,
        F_REQ   = 2'd1,
        F_DONE  = 2'd2
    } FETCH_STATE_T;

    // Byte address of the first byte of instruction pc_val.
    function automatic logic [31:0] byte_base(input logic [15:0] pc_val, input int bytes);
        return {16'd0, pc_val} * 32'(bytes);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - byte-wide program-memory read bus
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 19
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_rdata;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_byte_assembler.sv
// rtl/instr_byte_assembler.sv - MSB-first byte shift register with byte counter
module instr_byte_assembler
    import instr_fetch_unit_pkg::*;
#(
    parameter int BYTES = INSTR_BYTES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [8*BYTES-1:0] word_out,
    output logic               last_byte
);

    localparam int CW = $clog2(BYTES + 1);

    logic [CW-1:0] byte_idx;

    // clear only rewinds the counter; the word is fully overwritten by the next fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (shift_en) begin
            word_out <= {word_out[8*BYTES-9:0], byte_in};
            byte_idx <= last_byte ? '0 : byte_idx + CW'(1);
        end
    end

    assign last_byte = (byte_idx == CW'(BYTES - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - pc register and instruction fetch FSM; optional FETCH_LINE_CACHE_EN one-entry cache
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          INSTR_BYTES = 5,
    parameter int          IMEM_ADDR_W = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              next_pc,
    input  STATE_T                   current_state,
    output logic [15:0]              pc,
    output logic [8*INSTR_BYTES-1:0] instruction,
    output logic                     instr_valid,
    output logic                     fetch_busy,
    instr_fetch_unit_if.master       imem
);

    localparam int IW = 8 * INSTR_BYTES;

    FETCH_STATE_T         state;
    FETCH_STATE_T         state_nxt;
    logic                 load;
    logic                 draining;
    logic                 cache_hit;
    logic                 asm_clear;
    logic                 shift_en;
    logic                 last_byte;
    logic [IW-1:0]        word;
    logic [IMEM_ADDR_W-1:0] addr_q;

    assign load       = (current_state == WRITEBACK);
    assign fetch_busy = !instr_valid;

    instr_byte_assembler #(
        .BYTES (INSTR_BYTES)
    ) u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (shift_en),
        .byte_in   (imem.imem_rdata),
        .word_out  (word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= F_START;
        end else begin
            state <= state_nxt;
        end
    end

    // A load in F_REQ with no ack leaves the request in flight; draining waits it out.
    always_comb begin
        state_nxt = state;
        case (state)
            F_START: begin
                if (load) begin
                    state_nxt = F_START;
                end else if (cache_hit) begin
                    state_nxt = F_DONE;
                end else begin
                    state_nxt = F_REQ;
                end
            end
            F_REQ: begin
                if (imem.imem_ack && (load || draining)) begin
                    state_nxt = F_START;
                end else if (imem.imem_ack && !load && last_byte) begin
                    state_nxt = F_DONE;
                end
            end
            F_DONE: begin
                if (load) begin
                    state_nxt = F_START;
                end
            end
            default: state_nxt = F_START;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state == F_REQ);
        imem.imem_addr = addr_q;
        asm_clear      = (state == F_START);
        shift_en       = (state == F_REQ) && imem.imem_ack && !draining && !load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            addr_q      <= '0;
            draining    <= 1'b0;
        end else begin
            if (load) begin
                pc <= next_pc;
            end

            if (load) begin
                instr_valid <= 1'b0;
            end else if (shift_en && last_byte) begin
                instr_valid <= 1'b1;
            end else if (state == F_START && cache_hit) begin
                instr_valid <= 1'b1;
            end

            // F_START sees the already-loaded pc, so the base tracks the new target.
            if (state == F_START) begin
                addr_q <= IMEM_ADDR_W'(byte_base(pc, INSTR_BYTES));
            end else if (shift_en && !last_byte) begin
                addr_q <= addr_q + IMEM_ADDR_W'(1);
            end

            if (state == F_REQ) begin
                if (imem.imem_ack) begin
                    draining <= 1'b0;
                end else if (load) begin
                    draining <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_LINE_CACHE_EN
    logic          cache_valid;
    logic [15:0]   cache_tag;
    logic [IW-1:0] cache_data;
    logic          use_cache;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
            use_cache   <= 1'b0;
        end else begin
            if (shift_en && last_byte) begin
                cache_valid <= 1'b1;
                cache_tag   <= pc;
                cache_data  <= {word[IW-9:0], imem.imem_rdata};
            end
            if (state == F_START && !load) begin
                use_cache <= cache_hit;
            end
        end
    end

    assign cache_hit   = cache_valid && (cache_tag == pc);
    assign instruction = use_cache ? cache_data : word;
`else
    assign cache_hit   = 1'b0;
    assign instruction = word;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

`ifdef FETCH_LINE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] next_pc;
    STATE_T      current_state;
    logic [15:0] pc;
    logic [39:0] instruction;
    logic        instr_valid;
    logic        fetch_busy;

    instr_fetch_unit_if #(.ADDR_W(19)) imem_bus ();

    instr_fetch_unit #(
        .RESET_PC    (16'h0000),
        .INSTR_BYTES (5),
        .IMEM_ADDR_W (19)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .next_pc       (next_pc),
        .current_state (current_state),
        .pc            (pc),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .fetch_busy    (fetch_busy),
        .imem          (imem_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [18:0] a);
        logic [31:0] h;
        case (a)
            19'd0:   return 8'h12;
            19'd1:   return 8'h34;
            19'd2:   return 8'h56;
            19'd3:   return 8'h78;
            19'd4:   return 8'h9A;
            default: begin
                h = {13'd0, a} * 32'h9E3779B1;
                return h[23:16] ^ h[7:0];
            end
        endcase
    endfunction

    function automatic logic [18:0] base_of(input logic [15:0] p);
        int b;
        b = int'(p) * 5;
        return b[18:0];
    endfunction

    function automatic logic [39:0] expected_word(input logic [15:0] p);
        logic [39:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w = {w[31:0], mem_byte(base_of(p) + 19'(i))};
        return w;
    endfunction

    // Memory responder: per-byte random wait in [min_wait,max_wait], logs every ack it gives.
    int          min_wait = 0;
    int          max_wait = 0;
    bit          stale_ack = 1'b0;
    logic [18:0] ack_addr_q[$];
    int          ack_wait_q[$];

    initial begin
        int          cur_wait;
        int          cnt;
        logic [18:0] a0;
        cur_wait = -1;
        cnt = 0;
        a0 = '0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (stale_ack) begin
                stale_ack = 1'b0;
                imem_bus.imem_ack   = 1'b1;
                imem_bus.imem_rdata = 8'hEE;
                cur_wait = -1;
            end else if (reset || !imem_bus.imem_req) begin
                if (cur_wait >= 0 && cnt > 0 && !reset)
                    check("req_held_in_wait", 64'(imem_bus.imem_req), 64'(1));
                imem_bus.imem_ack = 1'b0;
                cur_wait = -1;
            end else begin
                if (cur_wait < 0) begin
                    cur_wait = $urandom_range(max_wait, min_wait);
                    cnt = 0;
                    a0 = imem_bus.imem_addr;
                end
                if (cnt == cur_wait) begin
                    if (cur_wait > 0) check("addr_held_in_wait", 64'(imem_bus.imem_addr), 64'(a0));
                    imem_bus.imem_ack   = 1'b1;
                    imem_bus.imem_rdata = mem_byte(imem_bus.imem_addr);
                    ack_addr_q.push_back(imem_bus.imem_addr);
                    ack_wait_q.push_back(cur_wait);
                    cur_wait = -1;
                end else begin
                    imem_bus.imem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    bit          m_cache_valid = 1'b0;
    logic [15:0] m_cache_tag = '0;

    task automatic clear_log();
        ack_addr_q.delete();
        ack_wait_q.delete();
    endtask

    task automatic load_pc(input logic [15:0] np);
        @(negedge clk);
        clear_log();
        next_pc = np;
        current_state = WRITEBACK;
        @(posedge clk);
        #1;
        current_state = FETCH;
    endtask

    task automatic verify_fetch(input string name, input logic [15:0] exp_pc, input bit may_hit);
        int n;
        int exp_lat;
        int nacks;
        bit hit;
        logic [18:0] base;
        hit = CACHE && may_hit && m_cache_valid && (m_cache_tag == exp_pc);
        base = base_of(exp_pc);
        n = 0;
        while (!instr_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".valid"}, 64'(instr_valid), 64'(1));
        if (hit) begin
            check({name, ".hit_latency"}, 64'(n), 64'(1));
            check({name, ".hit_no_req"}, 64'(ack_addr_q.size()), 64'(0));
        end else begin
            exp_lat = 1;
            foreach (ack_wait_q[i]) exp_lat += ack_wait_q[i] + 1;
            check({name, ".latency"}, 64'(n), 64'(exp_lat));
            check({name, ".nreq"}, 64'(ack_addr_q.size()), 64'(5));
            for (int i = 0; i < 5; i++)
                if (i < ack_addr_q.size())
                    check($sformatf("%s.addr%0d", name, i), 64'(ack_addr_q[i]), 64'(base + 19'(i)));
        end
        check({name, ".pc"}, 64'(pc), 64'(exp_pc));
        check({name, ".instr"}, 64'(instruction), 64'(expected_word(exp_pc)));
        check({name, ".busy"}, 64'(fetch_busy), 64'(0));
        m_cache_valid = 1'b1;
        m_cache_tag = exp_pc;
        nacks = ack_addr_q.size();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({name, ".hold_instr"}, 64'(instruction), 64'(expected_word(exp_pc)));
        check({name, ".hold_valid"}, 64'(instr_valid), 64'(1));
        check({name, ".hold_noreq"}, 64'(imem_bus.imem_req), 64'(0));
        check({name, ".hold_noack"}, 64'(ack_addr_q.size()), 64'(nacks));
    endtask

    task automatic wait_acks(input string name, input int k);
        int n;
        n = 0;
        while (ack_addr_q.size() < k && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".acks_seen"}, 64'(ack_addr_q.size()), 64'(k));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        clear_log();
        m_cache_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int          n;
        logic [15:0] np;
        reset = 1'b1;
        next_pc = 16'h0000;
        current_state = FETCH;
        repeat (3) @(posedge clk);
        #1;
        check("rst.pc", 64'(pc), 64'(0));
        check("rst.valid", 64'(instr_valid), 64'(0));
        check("rst.busy", 64'(fetch_busy), 64'(1));
        check("rst.req", 64'(imem_bus.imem_req), 64'(0));
        check("rst.addr", 64'(imem_bus.imem_addr), 64'(0));
        check("rst.instr", 64'(instruction), 64'(0));

        release_reset();
        verify_fetch("boot", 16'h0000, 1'b0);
        check("boot.word", 64'(instruction), 64'h12_3456_789A);

        load_pc(16'h0003);
        check("pc3.valid_low", 64'(instr_valid), 64'(0));
        verify_fetch("pc3", 16'h0003, 1'b1);

        min_wait = 3;
        max_wait = 3;
        load_pc(16'h0007);
        verify_fetch("wait3", 16'h0007, 1'b1);

        // Asynchronous reset while byte 2 is being requested.
        min_wait = 0;
        max_wait = 0;
        load_pc(16'h0009);
        wait_acks("midrst", 2);
        #1;
        reset = 1'b1;
        #1;
        check("midrst.req", 64'(imem_bus.imem_req), 64'(0));
        check("midrst.addr", 64'(imem_bus.imem_addr), 64'(0));
        check("midrst.pc", 64'(pc), 64'(0));
        check("midrst.valid", 64'(instr_valid), 64'(0));
        check("midrst.instr", 64'(instruction), 64'(0));
        repeat (2) @(posedge clk);
        stale_ack = 1'b1;
        release_reset();
        verify_fetch("midrst.restart", 16'h0000, 1'b0);

        min_wait = 0;
        max_wait = 2;
        load_pc(16'hFFFF);
        verify_fetch("top", 16'hFFFF, 1'b1);
        load_pc(16'h0000);
        verify_fetch("wrap0", 16'h0000, 1'b1);

        load_pc(16'h0000);
        verify_fetch("same_pc", 16'h0000, 1'b1);

        // Misbehaving core: load while a byte request is outstanding.
        min_wait = 2;
        max_wait = 2;
        load_pc(16'h0100);
        wait_acks("abort", 2);
        @(negedge clk);
        next_pc = 16'h0200;
        current_state = WRITEBACK;
        @(posedge clk);
        #1;
        current_state = FETCH;
        check("abort.valid_low", 64'(instr_valid), 64'(0));
        check("abort.req_kept", 64'(imem_bus.imem_req), 64'(1));
        check("abort.addr_kept", 64'(imem_bus.imem_addr), 64'(base_of(16'h0100) + 19'd2));
        n = 0;
        while (!instr_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort.valid", 64'(instr_valid), 64'(1));
        check("abort.nacks", 64'(ack_addr_q.size()), 64'(8));
        if (ack_addr_q.size() == 8) begin
            check("abort.drained_addr", 64'(ack_addr_q[2]), 64'(base_of(16'h0100) + 19'd2));
            for (int i = 0; i < 5; i++)
                check($sformatf("abort.addr%0d", i), 64'(ack_addr_q[3 + i]), 64'(base_of(16'h0200) + 19'(i)));
        end
        check("abort.pc", 64'(pc), 64'(16'h0200));
        check("abort.instr", 64'(instruction), 64'(expected_word(16'h0200)));
        m_cache_valid = 1'b1;
        m_cache_tag = 16'h0200;

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(3, 0))
                0:       np = pc;
                1:       np = m_cache_tag;
                2:       np = 16'($urandom());
                default: np = 16'($urandom_range(15, 0));
            endcase
            min_wait = 0;
            max_wait = $urandom_range(3, 0);
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                current_state = STATE_T'($urandom_range(2, 1));
            end
            @(negedge clk);
            current_state = FETCH;
            load_pc(np);
            verify_fetch($sformatf("rnd%0d", it), np, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
